// File: rtl/ex_stage_mdu.sv
// ---------------------------------------------------------------------------
// ex_stage_mdu -- execute stage sitting behind the ID/EX pipeline register.
//
// Performs the ALU operation selected by EX_ALUOp and registers the result,
// store data, destination register and memory/writeback controls into the
// EX/MEM boundary on every rising clock edge.
//
// Optional feature (macro EX_MDU_EN):
//   defined   : ALUOps 12..14 (MUL, DIVU, REMU) run through an iterative
//               unit that takes one step per cycle for MDU_CYCLES cycles. It
//               stalls the front end through ex_stall and feeds bubbles
//               into EX/MEM until the result is ready.
//   undefined : no multiply/divide hardware is built. ALUOps 12..14 finish
//               in a single cycle with result 0, and ex_stall is always 0.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   EX_ALUOp[3:0]         operation code
//   EX_D1, EX_D2          operand A, register operand B / store data
//   EX_Imm                sign-extended immediate
//   EX_RD, EX_RT          candidate destination registers
//   EX_RegDst, EX_ALUSrc  destination select (1 = rd), operand-B select (1 = imm)
//   EX_RegWrite, EX_MemToReg, EX_MEM_WEN, EX_MEM_REN   controls passed through
//   ex_flush              kill the instruction currently in EX
//   ex_stall              hold PC, IF/ID and ID/EX this cycle
//   MEM_*                 registered EX/MEM outputs
// ---------------------------------------------------------------------------
module ex_stage_mdu #(
    parameter int MDU_CYCLES = 32   // one iteration per data bit; must be 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  EX_ALUOp,
    input  logic [31:0] EX_D1,
    input  logic [31:0] EX_D2,
    input  logic [31:0] EX_Imm,
    input  logic [4:0]  EX_RD,
    input  logic [4:0]  EX_RT,
    input  logic        EX_RegDst,
    input  logic        EX_ALUSrc,
    input  logic        EX_RegWrite,
    input  logic        EX_MemToReg,
    input  logic        EX_MEM_WEN,
    input  logic        EX_MEM_REN,
    input  logic        ex_flush,
    output logic        ex_stall,
    output logic [31:0] MEM_ALUResult,
    output logic [31:0] MEM_WriteData,
    output logic [4:0]  MEM_WriteReg,
    output logic        MEM_RegWrite,
    output logic        MEM_MemToReg,
    output logic        MEM_MEM_WEN,
    output logic        MEM_MEM_REN
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

    // -----------------------------------------------------------------------
    // Single-cycle ALU
    // -----------------------------------------------------------------------
    logic [31:0] operand_b;
    logic [4:0]  dest_reg;
    logic [31:0] alu_result;

    assign operand_b = EX_ALUSrc ? EX_Imm : EX_D2;
    assign dest_reg  = EX_RegDst ? EX_RD : EX_RT;

    always_comb begin
        alu_result = 32'd0;
        case (EX_ALUOp)
            OP_ADD:  alu_result = EX_D1 + operand_b;
            OP_SUB:  alu_result = EX_D1 - operand_b;
            OP_AND:  alu_result = EX_D1 & operand_b;
            OP_OR:   alu_result = EX_D1 | operand_b;
            OP_XOR:  alu_result = EX_D1 ^ operand_b;
            OP_NOR:  alu_result = ~(EX_D1 | operand_b);
            OP_SLT:  alu_result = {31'd0, $signed(EX_D1) < $signed(operand_b)};
            OP_SLTU: alu_result = {31'd0, EX_D1 < operand_b};
            OP_SLL:  alu_result = EX_D1 << operand_b[4:0];
            OP_SRL:  alu_result = EX_D1 >> operand_b[4:0];
            OP_SRA:  alu_result = $signed(EX_D1) >>> operand_b[4:0];
            OP_LUI:  alu_result = operand_b << 16;
            OP_PASS: alu_result = operand_b;
            // MUL/DIVU/REMU yield 0 here; with the MDU present their real
            // result comes from mdu_result in the DONE cycle instead.
            default: alu_result = 32'd0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Iterative multiply/divide unit
    // -----------------------------------------------------------------------
    logic        mdu_hold;     // this cycle writes a bubble because of the MDU
    logic        mdu_done;     // this cycle delivers the MDU result
    logic [31:0] mdu_result;

`ifdef EX_MDU_EN
    localparam int CNT_W = $clog2(MDU_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

    mdu_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [3:0]       op_reg;
    // MUL : a_reg = multiplicand (shifts left), b_reg = multiplier (shifts
    //       right), acc_reg = running product.
    // DIV : a_reg = divisor, b_reg = dividend shifting out / quotient shifting
    //       in, acc_reg = partial remainder.
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic [31:0]      acc_reg;

    logic             is_mdu_op;
    logic             mdu_start;
    logic [32:0]      div_diff;

    assign is_mdu_op = (EX_ALUOp == OP_MUL) || (EX_ALUOp == OP_DIVU) ||
                       (EX_ALUOp == OP_REMU);
    assign mdu_start = (state_reg == IDLE) && is_mdu_op && !ex_flush;

    // Trial subtraction of the divisor from the remainder with the next
    // dividend bit shifted in; a clear borrow bit means the subtraction stays.
    // A zero divisor never borrows, which naturally yields an all-ones
    // quotient and a remainder equal to the dividend.
    assign div_diff = {acc_reg, b_reg[31]} - {1'b0, a_reg};

    assign mdu_hold   = !ex_flush && (mdu_start || (state_reg == BUSY));
    assign mdu_done   = (state_reg == DONE);
    assign mdu_result = (op_reg == OP_DIVU) ? b_reg : acc_reg;
    assign ex_stall   = !reset && mdu_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            op_reg    <= OP_ADD;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            acc_reg   <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mdu_start) begin
                        op_reg    <= EX_ALUOp;
                        acc_reg   <= 32'd0;
                        count_reg <= CNT_W'(MDU_CYCLES - 1);
                        state_reg <= BUSY;
                        if (EX_ALUOp == OP_MUL) begin
                            a_reg <= EX_D1;
                            b_reg <= operand_b;
                        end else begin
                            a_reg <= operand_b;
                            b_reg <= EX_D1;
                        end
                    end
                end
                BUSY: begin
                    if (ex_flush) begin
                        state_reg <= IDLE;
                    end else begin
                        if (op_reg == OP_MUL) begin
                            if (b_reg[0]) begin
                                acc_reg <= acc_reg + a_reg;
                            end
                            a_reg <= a_reg << 1;
                            b_reg <= b_reg >> 1;
                        end else if (!div_diff[32]) begin
                            acc_reg <= div_diff[31:0];
                            b_reg   <= {b_reg[30:0], 1'b1};
                        end else begin
                            acc_reg <= {acc_reg[30:0], b_reg[31]};
                            b_reg   <= {b_reg[30:0], 1'b0};
                        end
                        if (count_reg == '0) begin
                            state_reg <= DONE;
                        end else begin
                            count_reg <= count_reg - 1'b1;
                        end
                    end
                end
                // Upstream advances on this same edge, so returning to IDLE
                // cannot re-trigger the finished op.
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
`else
    assign mdu_hold   = 1'b0;
    assign mdu_done   = 1'b0;
    assign mdu_result = 32'd0;
    assign ex_stall   = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // EX/MEM boundary register
    // -----------------------------------------------------------------------
    logic [31:0] mem_result_next;
    logic [31:0] mem_wdata_next;
    logic [4:0]  mem_wreg_next;
    logic [3:0]  mem_ctrl_next;   // {RegWrite, MemToReg, MEM_WEN, MEM_REN}

    always_comb begin
        mem_result_next = 32'd0;
        mem_wdata_next  = 32'd0;
        mem_wreg_next   = 5'd0;
        mem_ctrl_next   = 4'd0;
        if (!ex_flush && !mdu_hold) begin
            mem_result_next = mdu_done ? mdu_result : alu_result;
            mem_wdata_next  = EX_D2;
            mem_wreg_next   = dest_reg;
            mem_ctrl_next   = {EX_RegWrite, EX_MemToReg, EX_MEM_WEN, EX_MEM_REN};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MEM_ALUResult <= 32'd0;
            MEM_WriteData <= 32'd0;
            MEM_WriteReg  <= 5'd0;
            MEM_RegWrite  <= 1'b0;
            MEM_MemToReg  <= 1'b0;
            MEM_MEM_WEN   <= 1'b0;
            MEM_MEM_REN   <= 1'b0;
        end else begin
            MEM_ALUResult <= mem_result_next;
            MEM_WriteData <= mem_wdata_next;
            MEM_WriteReg  <= mem_wreg_next;
            MEM_RegWrite  <= mem_ctrl_next[3];
            MEM_MemToReg  <= mem_ctrl_next[2];
            MEM_MEM_WEN   <= mem_ctrl_next[1];
            MEM_MEM_REN   <= mem_ctrl_next[0];
        end
    end

endmodule
